dma_controller_mc: RTL and testbench

//  Multi-channel successor to the single-channel DMA: NUM_CH independent channels move 32-bit DRAM words to/from 16-bit local RAM.

---
 rtl/dma_controller_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_controller_mc.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller_mc.sv
// Multi-channel DMA: NUM_CH round-robin channels moving 32-bit DRAM words to/from 16-bit local RAM.
// Optional feature macro DMA_IRQ_EN: registered completion interrupt gated by CONTROL b2.
module dma_controller_mc #(
  parameter int NUM_CH   = 2,
  parameter int LOCAL_AW = 16,
  parameter int DRAM_AW  = 24,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [15:0]         addr,
  input  logic [15:0]         data_in,
  input  logic                write_enable,
  output logic [15:0]         data_out,
  output logic [LOCAL_AW-1:0] ram_addr,
  input  logic [15:0]         ram_data_in,
  output logic [15:0]         ram_data_out,
  output logic                ram_we,
  output logic [DRAM_AW-1:0]  dram_addr,
  input  logic [31:0]         dram_data_in,
  output logic [31:0]         dram_data_out,
  output logic                dram_req_read,
  output logic                dram_req_write,
  input  logic                dram_data_valid,
  input  logic                dram_write_complete,
  output logic [NUM_CH-1:0]   busy,
  output logic                irq
);
  localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          PHI_W    = DRAM_AW - 16;
  localparam logic [31:0] NUM_CH_U = NUM_CH;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_RD_REQ, S_WR_LO, S_WR_HI,
    S_RD_LO, S_RD_HI, S_RD_WAIT, S_WR_REQ, S_NEXT
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count    [NUM_CH];
  logic [LOCAL_AW-1:0] loc_addr [NUM_CH];
  logic [DRAM_AW-1:0]  periph   [NUM_CH];
  logic [NUM_CH-1:0]   dir, ie, done;
  logic [CH_W-1:0]     cur, rr_ptr, grant;
  logic                grant_vld;
  logic [31:0]         word;

  logic [2:0]          reg_sel;
  logic [CH_W-1:0]     ch_sel;
  logic                ch_ok;
  logic [15:0]         rd_val;
  logic                last_word;
  logic [NUM_CH-1:0]   cur_onehot, rest_busy;
  logic                unused_addr_hi;

  assign reg_sel        = addr[2:0];
  assign ch_sel         = addr[CH_W+2:3];
  assign ch_ok          = (32'(ch_sel) < NUM_CH_U);
  assign unused_addr_hi = ^addr[15:CH_W+3];

  assign last_word  = (count[cur] == CNT_W'(1));
  assign cur_onehot = NUM_CH'(1) << cur;
  assign rest_busy  = busy & ~(last_word ? cur_onehot : '0);

  always_comb begin
    rd_val = '0;
    if (ch_ok) begin
      case (reg_sel)
        3'd0:    rd_val = 16'(count[ch_sel]);
        3'd1:    rd_val = 16'(loc_addr[ch_sel]);
        3'd2:    rd_val = periph[ch_sel][15:0];
        3'd3:    rd_val = 16'(periph[ch_sel][DRAM_AW-1:16]);
        3'd4:    rd_val = {13'b0, ie[ch_sel], dir[ch_sel], 1'b0};
        3'd5:    rd_val = {14'b0, done[ch_sel], busy[ch_sel]};
        default: rd_val = '0;
      endcase
    end
  end

  // Round-robin search starts at rr_ptr, which always points one past the last grant.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_CH_U; i++) begin
      if (!grant_vld && busy[CH_W'((32'(rr_ptr) + i) % NUM_CH_U)]) begin
        grant     = CH_W'((32'(rr_ptr) + i) % NUM_CH_U);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      rr_ptr   <= '0;
      word     <= '0;
      busy     <= '0;
      done     <= '0;
      dir      <= '0;
`ifdef DMA_IRQ_EN
      ie       <= '0;
`endif
      data_out <= '0;
      for (int unsigned i = 0; i < NUM_CH_U; i++) begin
        count[CH_W'(i)]    <= '0;
        loc_addr[CH_W'(i)] <= '0;
        periph[CH_W'(i)]   <= '0;
      end
    end else begin
      if (en && !write_enable)
        data_out <= rd_val;

      if (en && write_enable && ch_ok) begin
        if (!busy[ch_sel]) begin
          case (reg_sel)
            3'd0: count[ch_sel]                 <= CNT_W'(data_in);
            3'd1: loc_addr[ch_sel]              <= LOCAL_AW'(data_in);
            3'd2: periph[ch_sel][15:0]          <= data_in;
            3'd3: periph[ch_sel][DRAM_AW-1:16]  <= PHI_W'(data_in);
            3'd4: begin
              dir[ch_sel] <= data_in[1];
`ifdef DMA_IRQ_EN
              ie[ch_sel]  <= data_in[2];
`endif
              if (data_in[0]) begin
                if (count[ch_sel] == '0) begin
                  done[ch_sel] <= 1'b1;
                end else begin
                  busy[ch_sel] <= 1'b1;
                  done[ch_sel] <= 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
        if (reg_sel == 3'd5 && data_in[1])
          done[ch_sel] <= 1'b0;
      end

      case (state)
        S_IDLE: if (|busy) state <= S_ARB;
        S_ARB: begin
          if (grant_vld) begin
            cur    <= grant;
            rr_ptr <= (32'(grant) + 32'd1 == NUM_CH_U) ? '0 : grant + 1'b1;
            state  <= dir[grant] ? S_RD_LO : S_RD_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (dram_data_valid) begin
            word  <= dram_data_in;
            state <= S_WR_LO;
          end
        end
        S_WR_LO:  state <= S_WR_HI;
        S_WR_HI:  state <= S_NEXT;
        S_RD_LO:  state <= S_RD_HI;
        S_RD_HI: begin
          word[15:0] <= ram_data_in;
          state      <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          word[31:16] <= ram_data_in;
          state       <= S_WR_REQ;
        end
        S_WR_REQ: if (dram_write_complete) state <= S_NEXT;
        S_NEXT: begin
          // Completion status set here wins over a same-cycle STATUS clear.
          count[cur]    <= count[cur] - 1'b1;
          loc_addr[cur] <= loc_addr[cur] + LOCAL_AW'(2);
          periph[cur]   <= periph[cur] + 1'b1;
          if (last_word) begin
            busy[cur] <= 1'b0;
            done[cur] <= 1'b1;
          end
          state <= (|rest_busy) ? S_ARB : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr       = '0;
    ram_data_out   = '0;
    ram_we         = 1'b0;
    dram_addr      = '0;
    dram_data_out  = '0;
    dram_req_read  = 1'b0;
    dram_req_write = 1'b0;
    case (state)
      S_RD_REQ: begin
        dram_req_read = 1'b1;
        dram_addr     = periph[cur];
      end
      S_WR_LO: begin
        ram_we       = 1'b1;
        ram_addr     = loc_addr[cur];
        ram_data_out = word[15:0];
      end
      S_WR_HI: begin
        ram_we       = 1'b1;
        ram_addr     = loc_addr[cur] + 1'b1;
        ram_data_out = word[31:16];
      end
      S_RD_LO: ram_addr = loc_addr[cur];
      S_RD_HI: ram_addr = loc_addr[cur] + 1'b1;
      S_WR_REQ: begin
        dram_req_write = 1'b1;
        dram_addr      = periph[cur];
        dram_data_out  = word;
      end
      default: ;
    endcase
  end

`ifdef DMA_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(done & ie);
  end
`else
  assign ie  = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_dma_controller_mc.sv
// Self-checking bench for dma_controller_mc: local RAM / DRAM responders plus a transfer-level reference model.
module tb_dma_controller_mc;
  logic        clk = 1'b0;
  logic        rst, en, write_enable;
  logic [15:0] addr, data_in, data_out;
  logic [15:0] ram_addr, ram_data_in, ram_data_out;
  logic        ram_we;
  logic [23:0] dram_addr;
  logic [31:0] dram_data_in, dram_data_out;
  logic        dram_req_read, dram_req_write, dram_data_valid, dram_write_complete;
  logic [1:0]  busy;
  logic        irq;

  int tests = 0, fails = 0, proto_err = 0;

  dma_controller_mc #(.NUM_CH(2), .LOCAL_AW(16), .DRAM_AW(24), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_we(ram_we),
    .dram_addr(dram_addr), .dram_data_in(dram_data_in), .dram_data_out(dram_data_out),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_valid(dram_data_valid), .dram_write_complete(dram_write_complete),
    .busy(busy), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  logic [15:0] lram [0:65535];
  logic [31:0] dmem [int unsigned];

  // Synchronous-read local RAM: address sampled mid-cycle, data appears just after the edge.
  initial begin
    logic [15:0] a, d;
    logic        we;
    ram_data_in = '0;
    forever begin
      @(negedge clk);
      a = ram_addr; we = ram_we; d = ram_data_out;
      @(posedge clk);
      #1;
      ram_data_in = lram[a];
      if (we) lram[a] = d;
    end
  end

  // DRAM responder: answers a request after `lat` extra cycles and logs every completed access.
  int          lat = 1;
  bit          rand_lat = 0;
  logic [23:0] log_addr [$];
  logic [31:0] log_data [$];
  bit          log_wr   [$];
  int          log_cyc  [$];

  initial begin
    int          wcnt;
    bit          pulsed;
    logic [23:0] held_a;
    logic [31:0] held_d;
    wcnt = 0; pulsed = 0; held_a = '0; held_d = '0;
    dram_data_valid = 0; dram_write_complete = 0; dram_data_in = '0;
    forever begin
      @(negedge clk);
      dram_data_valid = 0; dram_write_complete = 0;
      if (int'(dram_req_read) + int'(dram_req_write) + int'(ram_we) > 1) proto_err++;
      if (pulsed && !rst && (dram_req_read || dram_req_write)) proto_err++;
      pulsed = 0;
      if (rst || !(dram_req_read || dram_req_write)) begin
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          held_a = dram_addr; held_d = dram_data_out;
        end else if (dram_addr !== held_a || (dram_req_write && dram_data_out !== held_d)) begin
          proto_err++;
        end
        if (wcnt >= lat) begin
          log_addr.push_back(dram_addr);
          log_wr.push_back(dram_req_write);
          log_cyc.push_back(wcnt + 1);
          if (dram_req_read) begin
            dram_data_in = dmem.exists(32'(dram_addr)) ? dmem[32'(dram_addr)] : 32'h0;
            dram_data_valid = 1;
            log_data.push_back(dram_data_in);
          end else begin
            dmem[32'(dram_addr)] = dram_data_out;
            dram_write_complete = 1;
            log_data.push_back(dram_data_out);
          end
          wcnt = 0; pulsed = 1;
          if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_wr.delete(); log_cyc.delete();
  endtask

  task automatic reg_wr(input int ch, input int r, input logic [15:0] d);
    @(negedge clk);
    en = 1; write_enable = 1; addr = 16'(ch * 8 + r); data_in = d;
    @(negedge clk);
    en = 0; write_enable = 0;
  endtask

  task automatic reg_rd(input int ch, input int r, output logic [15:0] d);
    @(negedge clk);
    en = 1; write_enable = 0; addr = 16'(ch * 8 + r);
    @(negedge clk);
    en = 0;
    d = data_out;
  endtask

  task automatic setup_ch(input int ch, input int cnt, input logic [15:0] loc,
                          input logic [23:0] per, input bit d, input bit go);
    reg_wr(ch, 0, 16'(cnt));
    reg_wr(ch, 1, loc);
    reg_wr(ch, 2, per[15:0]);
    reg_wr(ch, 3, {8'h0, per[23:16]});
    if (go) reg_wr(ch, 4, {14'h0, d, 1'b1});
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 2'b00 && n < budget);
    tests++;
    if (busy !== 2'b00) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 00", nm, busy, n);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1; en = 0; write_enable = 0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, irq, dram_req_read, dram_req_write, ram_we, data_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b irq=%b rr=%b rw=%b we=%b dout=%h, required all 0",
               busy, irq, dram_req_read, dram_req_write, ram_we, data_out);
    end
    rst = 0;
    reg_rd(0, 0, v); check16("reset_count0", v, 16'h0);
    reg_rd(1, 5, v); check16("reset_status1", v, 16'h0);
  endtask

  // Reference: expected words written by a DRAM->RAM transfer, from the addressing rules alone.
  task automatic test_dram_to_ram();
    logic [15:0] v;
    logic [15:0] exp_w [4];
    dmem[32'h00f00d] = 32'hdeadbeef;
    dmem[32'h00f00e] = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      exp_w[2*k]   = dmem[32'h00f00d + 32'(k)][15:0];
      exp_w[2*k+1] = dmem[32'h00f00d + 32'(k)][31:16];
    end
    setup_ch(0, 2, 16'h0100, 24'h00f00d, 1'b0, 1'b1);
    wait_idle(200, "d2r");
    for (int i = 0; i < 4; i++) check16($sformatf("d2r_ram%0d", i), lram[16'h0100 + 16'(i)], exp_w[i]);
    reg_rd(0, 5, v); check16("d2r_status", v, 16'h0002);
    reg_rd(0, 0, v); check16("d2r_count", v, 16'h0000);
    reg_rd(0, 1, v); check16("d2r_local", v, 16'h0104);
    reg_rd(0, 2, v); check16("d2r_periph_lo", v, 16'hf00f);
    reg_wr(0, 5, 16'h0002);
    reg_rd(0, 5, v); check16("d2r_status_clr", v, 16'h0000);
  endtask

  task automatic test_ram_to_dram();
    lram[16'h0200] = 16'hbeef;
    lram[16'h0201] = 16'hcafe;
    lat = 2;
    clear_log();
    setup_ch(1, 1, 16'h0200, 24'h345678, 1'b1, 1'b1);
    wait_idle(200, "r2d");
    lat = 1;
    tests++;
    if (log_wr.size() != 1 || !log_wr[0] || log_addr[0] !== 24'h345678 ||
        log_data[0] !== 32'hcafebeef || log_cyc[0] != 3) begin
      fails++;
      $display("FAIL r2d_write: n=%0d addr=%h data=%h cycles=%0d, required 1 write addr=345678 data=cafebeef cycles=3",
               log_wr.size(), log_addr.size() ? log_addr[0] : 24'h0,
               log_data.size() ? log_data[0] : 32'h0, log_cyc.size() ? log_cyc[0] : 0);
    end
    reg_wr(1, 5, 16'h0002);
  endtask

  task automatic test_round_robin();
    int          rem [2];
    int          issued [2];
    int          p;
    logic [23:0] base [2];
    logic [23:0] exp_seq [$];
    reset_dut();
    base[0] = 24'h001000; base[1] = 24'h002000;
    rem[0] = 2; rem[1] = 2; issued[0] = 0; issued[1] = 0; p = 0;
    while (rem[0] + rem[1] > 0) begin
      int c;
      c = (rem[p] > 0) ? p : 1 - p;
      exp_seq.push_back(base[c] + 24'(issued[c]));
      issued[c]++; rem[c]--;
      p = 1 - c;
    end
    clear_log();
    setup_ch(0, 2, 16'h0400, base[0], 1'b0, 1'b0);
    setup_ch(1, 2, 16'h0500, base[1], 1'b0, 1'b0);
    reg_wr(0, 4, 16'h0001);
    reg_wr(1, 4, 16'h0001);
    wait_idle(300, "rr");
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (log_addr.size() <= i || log_addr[i] !== exp_seq[i]) begin
        fails++;
        $display("FAIL rr_order%0d: addr=%h, required %h", i,
                 log_addr.size() > i ? log_addr[i] : 24'hx, exp_seq[i]);
      end
    end
  endtask

  task automatic test_zero_and_busy_write();
    logic [15:0] v;
    clear_log();
    reg_wr(0, 0, 16'h0000);
    reg_wr(0, 4, 16'h0001);
    reg_rd(0, 5, v); check16("zero_status", v, 16'h0002);
    tests++;
    if (log_addr.size() != 0 || busy !== 2'b00) begin
      fails++;
      $display("FAIL zero_traffic: accesses=%0d busy=%b, required 0 and 00", log_addr.size(), busy);
    end
    lat = 20;
    setup_ch(1, 3, 16'h0600, 24'h300000, 1'b0, 1'b1);
    reg_wr(1, 0, 16'h0055);
    reg_wr(1, 1, 16'h1234);
    reg_rd(1, 0, v); check16("busy_count_kept", v, 16'h0003);
    reg_rd(1, 1, v); check16("busy_local_kept", v, 16'h0600);
    lat = 1;
    wait_idle(300, "busy_wr");
    reg_rd(1, 5, v); check16("busy_ch_status", v, 16'h0002);
  endtask

  task automatic test_wrap();
    dmem[32'hffffff] = 32'h0badf00d;
    dmem[32'h000000] = 32'h600dcafe;
    clear_log();
    setup_ch(0, 2, 16'hfffe, 24'hffffff, 1'b0, 1'b1);
    wait_idle(200, "wrap");
    check16("wrap_fffe", lram[16'hfffe], 16'hf00d);
    check16("wrap_ffff", lram[16'hffff], 16'h0bad);
    check16("wrap_0000", lram[16'h0000], 16'hcafe);
    check16("wrap_0001", lram[16'h0001], 16'h600d);
    tests++;
    if (log_addr.size() != 2 || log_addr[0] !== 24'hffffff || log_addr[1] !== 24'h000000) begin
      fails++;
      $display("FAIL wrap_periph: n=%0d, required reads at ffffff then 000000", log_addr.size());
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int it = 0; it < 6; it++) begin
      bit          e_dram [$];
      int unsigned e_addr [$];
      logic [31:0] e_val  [$];
      int          cnt [2];
      logic [15:0] loc [2];
      logic [23:0] per [2];
      bit          d [2];
      rand_lat = 1;
      for (int ch = 0; ch < 2; ch++) begin
        cnt[ch] = $urandom_range(1, 4);
        loc[ch] = 16'(ch == 0 ? 16'h1000 : 16'h3000) + 16'($urandom_range(0, 255));
        per[ch] = 24'(ch == 0 ? 24'h100000 : 24'h200000) + 24'($urandom_range(0, 4095));
        d[ch]   = 1'($urandom_range(0, 1));
        for (int k = 0; k < cnt[ch]; k++) begin
          logic [15:0] la;
          logic [23:0] pa;
          la = loc[ch] + 16'(2 * k);
          pa = per[ch] + 24'(k);
          if (!d[ch]) begin
            dmem[32'(pa)] = $urandom;
            e_dram.push_back(0); e_addr.push_back(32'(la));       e_val.push_back(32'(dmem[32'(pa)][15:0]));
            e_dram.push_back(0); e_addr.push_back(32'(la + 16'd1)); e_val.push_back(32'(dmem[32'(pa)][31:16]));
          end else begin
            lram[la] = 16'($urandom); lram[la + 16'd1] = 16'($urandom);
            e_dram.push_back(1); e_addr.push_back(32'(pa)); e_val.push_back({lram[la + 16'd1], lram[la]});
          end
        end
      end
      setup_ch(0, cnt[0], loc[0], per[0], d[0], 1'b1);
      setup_ch(1, cnt[1], loc[1], per[1], d[1], 1'b1);
      wait_idle(600, "rand");
      for (int i = 0; i < e_addr.size(); i++) begin
        logic [31:0] got;
        got = e_dram[i] ? (dmem.exists(e_addr[i]) ? dmem[e_addr[i]] : 32'hx) : 32'(lram[16'(e_addr[i])]);
        tests++;
        if (got !== e_val[i]) begin
          fails++;
          $display("FAIL rand%0d_%s_%h: got %h, required %h", it, e_dram[i] ? "dram" : "ram",
                   e_addr[i], got, e_val[i]);
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        reg_rd(ch, 5, v); check16($sformatf("rand%0d_status%0d", it, ch), v, 16'h0002);
        reg_wr(ch, 5, 16'h0002);
      end
    end
    rand_lat = 0; lat = 1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int n;
    reset_dut();
    lat = 50;
    setup_ch(0, 2, 16'h0700, 24'h050000, 1'b0, 1'b1);
    n = 0;
    while (!dram_req_read && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (!dram_req_read) begin
      fails++;
      $display("FAIL rstmid_req: dram_req_read=0 after %0d cycles, required 1", n);
    end
    rst = 1;
    @(negedge clk);
    tests++;
    if (dram_req_read !== 1'b0 || dram_req_write !== 1'b0 || busy !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_drop: rr=%b rw=%b busy=%b, required 0 0 00", dram_req_read, dram_req_write, busy);
    end
    rst = 0; lat = 1;
    reg_rd(0, 0, v); check16("rstmid_count", v, 16'h0000);
    reg_wr(0, 4, 16'h0005);
    repeat (2) @(negedge clk);
    tests++;
`ifdef DMA_IRQ_EN
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_set: irq=%b, required 1", irq);
    end
`else
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_tied: irq=%b, required 0", irq);
    end
`endif
    reg_rd(0, 5, v); check16("irq_status", v, 16'h0002);
    reg_wr(0, 5, 16'h0002);
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear: irq=%b, required 0", irq);
    end
    reg_rd(0, 5, v); check16("irq_status_clr", v, 16'h0000);
  endtask

  task automatic test_protocol();
    tests++;
    if (proto_err != 0) begin
      fails++;
      $display("FAIL bus_protocol: %0d violations, required 0", proto_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) lram[i] = '0;
    test_reset();
    test_dram_to_ram();
    test_ram_to_dram();
    test_round_robin();
    test_zero_and_busy_write();
    test_wrap();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
